usb_fs_rx_decoder: RTL and testbench
====================================

Name: usb_fs_rx_decoder

Overview:
- Full-speed (12 Mb/s) USB receive front end.
- Sits directly downstream of the Pmod D+/D- bidirectional pad stage and consumes the raw line levels.
- Oversamples the line, recovers the bit clock, detects SYNC, NRZI-decodes, strips stuffed bits, assembles bytes LSB-first and flags EOP and line errors.
- Feeds the packet/PID layer with a byte-valid strobe interface.

Parameters:
- OVERSAMPLE, 4: clk_i cycles per USB bit (clk_i = 48 MHz); must be >= 4 and even.
- SYNC_MIN_ZEROS, 5: minimum decoded zeros before the SYNC-terminating one (tolerates lost leading SYNC bits).
- STUFF_LIMIT, 6: consecutive decoded ones after which a stuffed zero is mandatory.

Ports:
- clk_i, in, 1: system clock, 48 MHz.
- rst_i, in, 1: asynchronous active-low reset.
- dp_i, in, 1: raw D+ level from pad, asynchronous.
- dn_i, in, 1: raw D- level from pad, asynchronous.
- rx_data_o, out, 8: last assembled byte, LSB received first.
- rx_valid_o, out, 1: one-cycle strobe; rx_data_o is valid this cycle.
- rx_active_o, out, 1: high from SYNC end to EOP or error.
- rx_eop_o, out, 1: one-cycle strobe at valid EOP.
- rx_err_o, out, 1: one-cycle strobe on stuff error, SE1, or partial byte at EOP.
- line_state_o, out, 2: synchronized line state: 00 SE0, 01 J (dp=1, dn=0), 10 K, 11 SE1.

Behaviour:
- Reset (rst_i low, async): all outputs 0, line_state_o = 00, FSM IDLE, phase counter 0, shift/ones/bit counters 0. Takes effect immediately, including mid-packet; no partial byte or strobe is emitted after release.
- Synchronizer: 2-FF on dp_i and dn_i. line_state_o is registered from the synchronizer output, 3 clk latency from the pad.
- Bit recovery:
  - Phase counter 0..OVERSAMPLE-1, free-running with wrap.
  - Reset to 0 on any J<->K change of the synchronized state.
  - bit_strobe fires when counter == OVERSAMPLE/2 - 1, i.e. mid-bit.
- NRZI decode at bit_strobe: decoded bit = 1 if sampled J/K equals the previous sample, else 0. The previous sample is preset to J on entering SYNC.
- FSM, evaluated at bit_strobe unless noted:
  - IDLE: wait for K sampled; go to SYNC, zero count = 1.
  - SYNC:
    - decoded 0: increment zero count.
    - decoded 1 with zero count >= SYNC_MIN_ZEROS: go to DATA; rx_active_o = 1 on the next clk; clear bit count and ones count.
    - decoded 1 with fewer zeros, or SE0/SE1 sampled: go to IDLE silently.
  - DATA:
    - SE1 sampled: rx_err_o pulse, rx_active_o = 0, go to WAIT_IDLE.
    - SE0 sampled: go to EOP.
    - ones count == STUFF_LIMIT and decoded 0: drop the bit, ones count = 0.
    - ones count == STUFF_LIMIT and decoded 1: rx_err_o pulse, rx_active_o = 0, partial byte discarded, go to WAIT_IDLE.
    - otherwise: shift the bit into the MSB of the shift register (right shift); ones count increments on 1, clears on 0; bit count increments.
    - bit count reaching 8: rx_data_o <= shift value, rx_valid_o high exactly 1 clk (the clk after the 8th bit's strobe); bit count = 0.
  - EOP:
    - second consecutive SE0 sample followed by J sample: rx_eop_o pulse, rx_active_o = 0, go to IDLE.
    - bit count != 0 at EOP: rx_err_o pulses in the same cycle as rx_eop_o; the partial byte is discarded.
    - K or SE1 instead of SE0/J: rx_err_o pulse, go to WAIT_IDLE.
    - Note: the ones count is not reset by SE0; a stuff decision never occurs during EOP.
  - WAIT_IDLE: stay until J is sampled at 2 consecutive bit_strobes, then go to IDLE. No strobes are emitted in this state.
- Strobe coincidence: rx_valid_o for the final full byte always precedes rx_eop_o by >= 1 clk. rx_valid_o and rx_err_o never assert together.
- rx_data_o holds its value between strobes.

Decomposition:
- Package usb_rx_pkg holds:
  - line-state encodings (SE0/J/K/SE1)
  - FSM state enum (IDLE, SYNC, DATA, EOP, WAIT_IDLE)
  - default constants for STUFF_LIMIT and SYNC_MIN_ZEROS
- Sub-module usb_rx_dpll: synchronizer, line-state decode, phase counter, bit_strobe generation.
- The top level holds the FSM, NRZI decoder, unstuffer and byte assembly.

Test Plan:
- SYNC (KJKJKJKK) + byte 0xA5 + SE0,SE0,J -> rx_active_o rises after SYNC; one rx_valid_o with rx_data_o=0xA5; rx_eop_o pulse; rx_active_o low; rx_err_o never high.
- Byte 0xFF sent with the stuffed zero after six ones -> single rx_valid_o, rx_data_o=0xFF, no rx_err_o.
- Seven consecutive decoded ones (no stuff bit) -> rx_err_o pulse, rx_active_o falls, no rx_valid_o for that byte; after SE0 then 2 bits of J, a following SYNC+0x3C is received correctly.
- Byte 0xC3 then 3 extra bits then EOP -> rx_valid_o with 0xC3, then rx_eop_o and rx_err_o in the same cycle.
- rst_i low mid-byte -> all outputs 0 in the same cycle (async); after release, a new SYNC+0x5A decodes to 0x5A.
- Every edge jittered ±1 clk at OVERSAMPLE=4, byte sequence 0x00,0x80,0x7E -> all three bytes correct, no rx_err_o.

Source files
------------

// File: rtl/usb_rx_pkg.sv
// rtl/usb_rx_pkg.sv - shared encodings and defaults for the full-speed USB receive path
package usb_rx_pkg;

  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_J   = 2'b01;
  localparam logic [1:0] LS_K   = 2'b10;
  localparam logic [1:0] LS_SE1 = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP,
    ST_WAIT_IDLE
  } rx_state_t;

  localparam int STUFF_LIMIT_DEF    = 6;
  localparam int SYNC_MIN_ZEROS_DEF = 5;

endpackage

// File: rtl/usb_rx_dpll.sv
// rtl/usb_rx_dpll.sv - pad synchronizer, line-state register and mid-bit strobe recovery
module usb_rx_dpll
  import usb_rx_pkg::*;
#(
  parameter int OVERSAMPLE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dp,
  input  logic       dn,
  output logic [1:0] line_state,
  output logic       bit_strobe
);

  localparam int PW = $clog2(OVERSAMPLE);

  logic [1:0]    meta;
  logic [1:0]    sync;
  logic [PW-1:0] phase;
  logic          jk_change;

  // Only J<->K transitions carry timing; SE0 edges leave the phase alone.
  assign jk_change = (sync != line_state) &&
                     (sync == LS_J || sync == LS_K) &&
                     (line_state == LS_J || line_state == LS_K);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta       <= LS_SE0;
      sync       <= LS_SE0;
      line_state <= LS_SE0;
      phase      <= '0;
    end else begin
      meta       <= {dn, dp};
      sync       <= meta;
      line_state <= sync;
      if (jk_change || phase == PW'(OVERSAMPLE - 1)) begin
        phase <= '0;
      end else begin
        phase <= phase + PW'(1);
      end
    end
  end

  assign bit_strobe = (phase == PW'(OVERSAMPLE / 2 - 1));

endmodule

// File: rtl/usb_fs_rx_decoder.sv
// rtl/usb_fs_rx_decoder.sv - USB FS receiver: SYNC hunt, NRZI decode, bit unstuffing, byte assembly, EOP/error flags
module usb_fs_rx_decoder
  import usb_rx_pkg::*;
#(
  parameter int OVERSAMPLE     = 4,
  parameter int SYNC_MIN_ZEROS = SYNC_MIN_ZEROS_DEF,
  parameter int STUFF_LIMIT    = STUFF_LIMIT_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       dp_i,
  input  logic       dn_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_active_o,
  output logic       rx_eop_o,
  output logic       rx_err_o,
  output logic [1:0] line_state_o
);

  localparam logic [3:0] ONES_MAX  = 4'(STUFF_LIMIT);
  localparam logic [3:0] ZEROS_MIN = 4'(SYNC_MIN_ZEROS);

  rx_state_t  state, state_n;
  logic [1:0] ls;
  logic       bit_strobe;
  logic [3:0] zero_cnt, zero_cnt_n;
  logic [3:0] ones_cnt, ones_cnt_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shift, shift_n, data_n;
  logic       prev_k, prev_k_n;
  logic       se0_two, se0_two_n;
  logic       j_seen, j_seen_n;
  logic       valid_n, active_n, eop_n, err_n;
  logic       is_j, is_k, is_jk, dbit;

  usb_rx_dpll #(.OVERSAMPLE(OVERSAMPLE)) u_dpll (
    .clk        (clk_i),
    .rst_n      (rst_i),
    .dp         (dp_i),
    .dn         (dn_i),
    .line_state (ls),
    .bit_strobe (bit_strobe)
  );

  assign line_state_o = ls;
  assign is_j  = (ls == LS_J);
  assign is_k  = (ls == LS_K);
  assign is_jk = is_j || is_k;
  // NRZI: no transition means a one.
  assign dbit  = (is_k == prev_k);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= ST_IDLE;
      zero_cnt    <= '0;
      ones_cnt    <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      prev_k      <= 1'b0;
      se0_two     <= 1'b0;
      j_seen      <= 1'b0;
      rx_data_o   <= '0;
      rx_valid_o  <= 1'b0;
      rx_active_o <= 1'b0;
      rx_eop_o    <= 1'b0;
      rx_err_o    <= 1'b0;
    end else begin
      state       <= state_n;
      zero_cnt    <= zero_cnt_n;
      ones_cnt    <= ones_cnt_n;
      bit_cnt     <= bit_cnt_n;
      shift       <= shift_n;
      prev_k      <= prev_k_n;
      se0_two     <= se0_two_n;
      j_seen      <= j_seen_n;
      rx_data_o   <= data_n;
      rx_valid_o  <= valid_n;
      rx_active_o <= active_n;
      rx_eop_o    <= eop_n;
      rx_err_o    <= err_n;
    end
  end

  always_comb begin
    state_n    = state;
    zero_cnt_n = zero_cnt;
    ones_cnt_n = ones_cnt;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    prev_k_n   = prev_k;
    se0_two_n  = se0_two;
    j_seen_n   = j_seen;
    data_n     = rx_data_o;
    valid_n    = 1'b0;
    active_n   = rx_active_o;
    eop_n      = 1'b0;
    err_n      = 1'b0;

    if (bit_strobe) begin
      if (is_jk) prev_k_n = is_k;

      case (state)
        ST_IDLE: begin
          // The first K is a zero relative to the idle J level.
          if (is_k) begin
            state_n    = ST_SYNC;
            zero_cnt_n = 4'd1;
          end
        end

        ST_SYNC: begin
          if (!is_jk) begin
            state_n = ST_IDLE;
          end else if (!dbit) begin
            if (zero_cnt != 4'hF) zero_cnt_n = zero_cnt + 4'd1;
          end else if (zero_cnt >= ZEROS_MIN) begin
            state_n    = ST_DATA;
            active_n   = 1'b1;
            bit_cnt_n  = '0;
            ones_cnt_n = '0;
          end else begin
            state_n = ST_IDLE;
          end
        end

        ST_DATA: begin
          if (ls == LS_SE1) begin
            err_n    = 1'b1;
            active_n = 1'b0;
            j_seen_n = 1'b0;
            state_n  = ST_WAIT_IDLE;
          end else if (ls == LS_SE0) begin
            se0_two_n = 1'b0;
            state_n   = ST_EOP;
          end else if (ones_cnt == ONES_MAX) begin
            if (!dbit) begin
              ones_cnt_n = '0;
            end else begin
              err_n    = 1'b1;
              active_n = 1'b0;
              j_seen_n = 1'b0;
              state_n  = ST_WAIT_IDLE;
            end
          end else begin
            shift_n    = {dbit, shift[7:1]};
            ones_cnt_n = dbit ? ones_cnt + 4'd1 : 4'd0;
            if (bit_cnt == 3'd7) begin
              data_n    = shift_n;
              valid_n   = 1'b1;
              bit_cnt_n = '0;
            end else begin
              bit_cnt_n = bit_cnt + 3'd1;
            end
          end
        end

        ST_EOP: begin
          if (ls == LS_SE0) begin
            se0_two_n = 1'b1;
          end else if (is_j && se0_two) begin
            eop_n    = 1'b1;
            err_n    = (bit_cnt != 3'd0);
            active_n = 1'b0;
            state_n  = ST_IDLE;
          end else begin
            err_n    = 1'b1;
            active_n = 1'b0;
            j_seen_n = 1'b0;
            state_n  = ST_WAIT_IDLE;
          end
        end

        ST_WAIT_IDLE: begin
          if (is_j) begin
            if (j_seen) state_n = ST_IDLE;
            j_seen_n = 1'b1;
          end else begin
            j_seen_n = 1'b0;
          end
        end

        default: state_n = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_fs_rx_decoder.sv
// tb/tb_usb_fs_rx_decoder.sv - randomized packet-level bench for usb_fs_rx_decoder
`timescale 1ns/1ps
module tb_usb_fs_rx_decoder;

  localparam int OS = 4;
  localparam logic [1:0] LJ   = 2'b01;
  localparam logic [1:0] LK   = 2'b10;
  localparam logic [1:0] LSE0 = 2'b00;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic dp_i  = 1'b1;
  logic dn_i  = 1'b0;
  logic [7:0] rx_data_o;
  logic       rx_valid_o, rx_active_o, rx_eop_o, rx_err_o;
  logic [1:0] line_state_o;

  int checks = 0;
  int passed = 0;

  usb_fs_rx_decoder #(.OVERSAMPLE(OS)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .dp_i         (dp_i),
    .dn_i         (dn_i),
    .rx_data_o    (rx_data_o),
    .rx_valid_o   (rx_valid_o),
    .rx_active_o  (rx_active_o),
    .rx_eop_o     (rx_eop_o),
    .rx_err_o     (rx_err_o),
    .line_state_o (line_state_o)
  );

  always #10 clk_i = ~clk_i;

  logic [7:0] got_q[$];
  int n_eop, n_err, n_rise, n_ee;
  int tot_ve = 0;
  int tot_vo = 0;
  logic act_d = 1'b0;

  always @(negedge clk_i) begin
    if (rx_valid_o) got_q.push_back(rx_data_o);
    if (rx_eop_o) n_eop++;
    if (rx_err_o) n_err++;
    if (rx_eop_o && rx_err_o) n_ee++;
    if (rx_valid_o && rx_err_o) tot_ve++;
    if (rx_valid_o && rx_eop_o) tot_vo++;
    if (rx_active_o && !act_d) n_rise++;
    act_d = rx_active_o;
  end

  logic [1:0] sym_q[$];
  logic [1:0] cur;
  bit         tx_bits[$];
  logic [7:0] exp_q[$];
  int exp_eop, exp_err;

  task automatic clear_all;
    sym_q.delete(); tx_bits.delete(); exp_q.delete(); got_q.delete();
    exp_eop = 0; exp_err = 0; n_eop = 0; n_err = 0; n_rise = 0; n_ee = 0;
  endtask

  task automatic put_bit(input bit b);
    if (!b) cur = (cur == LJ) ? LK : LJ;
    sym_q.push_back(cur);
  endtask

  task automatic add_byte(input logic [7:0] b);
    for (int j = 0; j < 8; j++) tx_bits.push_back(b[j]);
  endtask

  task automatic add_rand_bits(input int n);
    for (int j = 0; j < n; j++) tx_bits.push_back(1'($urandom_range(1, 0)));
  endtask

  // Line encoding of tx_bits: idle, SYNC, stuffed NRZI data, optional EOP.
  task automatic emit(input bit stuff_on, input bit with_eop);
    int ones;
    ones = 0;
    for (int i = 0; i < 4; i++) sym_q.push_back(LJ);
    cur = LJ;
    for (int i = 0; i < 7; i++) put_bit(1'b0);
    put_bit(1'b1);
    foreach (tx_bits[i]) begin
      put_bit(tx_bits[i]);
      ones = tx_bits[i] ? ones + 1 : 0;
      if (stuff_on && ones == 6) begin
        put_bit(1'b0);
        ones = 0;
      end
    end
    if (with_eop) begin
      sym_q.push_back(LSE0);
      sym_q.push_back(LSE0);
      for (int i = 0; i < 4; i++) sym_q.push_back(LJ);
    end
  endtask

  // Expected receiver view: whole bytes LSB-first, one EOP, error on leftover bits.
  task automatic model_packet;
    logic [7:0] b;
    for (int k = 0; k + 8 <= tx_bits.size(); k += 8) begin
      for (int j = 0; j < 8; j++) b[j] = tx_bits[k + j];
      exp_q.push_back(b);
    end
    exp_eop++;
    if (tx_bits.size() % 8 != 0) exp_err++;
  endtask

  // Edges move by -1..+1 clk; an edge never lands more than 1 clk later than its predecessor's offset.
  task automatic play(input bit jitter);
    int offs[$];
    int prev_off, hi, o, dur, nxt;
    prev_off = 0;
    offs.push_back(0);
    for (int i = 1; i < sym_q.size(); i++) begin
      o = 0;
      if (jitter && sym_q[i] != sym_q[i-1] &&
          (sym_q[i] == LJ || sym_q[i] == LK) && (sym_q[i-1] == LJ || sym_q[i-1] == LK)) begin
        hi = (prev_off + 1 > 1) ? 1 : prev_off + 1;
        o = int'($urandom_range(hi + 1, 0)) - 1;
        prev_off = o;
      end
      offs.push_back(o);
    end
    for (int i = 0; i < sym_q.size(); i++) begin
      nxt = (i + 1 < sym_q.size()) ? offs[i+1] : 0;
      dur = OS + nxt - offs[i];
      {dn_i, dp_i} = sym_q[i];
      repeat (dur) @(posedge clk_i);
      #1;
    end
    sym_q.delete();
  endtask

  task automatic idle(input int n);
    {dn_i, dp_i} = LJ;
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  function automatic int bytes_diff();
    int d;
    d = (got_q.size() != exp_q.size()) ? 1 : 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) d++;
    return d;
  endfunction

  task automatic test_reset;
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if ({rx_data_o, rx_valid_o, rx_active_o, rx_eop_o, rx_err_o, line_state_o} !== 14'd0)
      $display("FAIL reset_outputs: got %h required 0",
               {rx_data_o, rx_valid_o, rx_active_o, rx_eop_o, rx_err_o, line_state_o});
    else passed++;
    rst_i = 1'b1;
    idle(8);
    checks++;
    if (line_state_o !== LJ) $display("FAIL idle_line_state: got %b required %b", line_state_o, LJ);
    else passed++;
  endtask

  task automatic test_basic;
    clear_all();
    add_byte(8'hA5); emit(1, 1); model_packet();
    play(0); idle(20);
    checks++;
    if (bytes_diff() !== 0) $display("FAIL basic_bytes: got %0d bytes (first %h) required A5", got_q.size(), got_q.size() ? got_q[0] : 8'h00);
    else passed++;
    checks++;
    if (n_eop !== 1) $display("FAIL basic_eop: got %0d required 1", n_eop); else passed++;
    checks++;
    if (n_err !== 0) $display("FAIL basic_err: got %0d required 0", n_err); else passed++;
    checks++;
    if (n_rise !== 1) $display("FAIL basic_active_rise: got %0d required 1", n_rise); else passed++;
    checks++;
    if (rx_active_o !== 1'b0) $display("FAIL basic_active_end: got %b required 0", rx_active_o); else passed++;
  endtask

  task automatic test_stuff_ff;
    clear_all();
    add_byte(8'hFF); emit(1, 1); model_packet();
    play(0); idle(20);
    checks++;
    if (bytes_diff() !== 0) $display("FAIL ff_bytes: got %0d bytes (first %h) required FF", got_q.size(), got_q.size() ? got_q[0] : 8'h00);
    else passed++;
    checks++;
    if (n_err !== 0) $display("FAIL ff_err: got %0d required 0", n_err); else passed++;
    checks++;
    if (n_eop !== 1) $display("FAIL ff_eop: got %0d required 1", n_eop); else passed++;
  endtask

  task automatic test_stuff_error;
    clear_all();
    for (int i = 0; i < 7; i++) tx_bits.push_back(1'b1);
    emit(0, 0);
    exp_err = 1;
    sym_q.push_back(LSE0); sym_q.push_back(LJ); sym_q.push_back(LJ);
    tx_bits.delete();
    add_byte(8'h3C); emit(1, 1); model_packet();
    play(0); idle(20);
    checks++;
    if (n_err !== exp_err) $display("FAIL stuff_err_count: got %0d required %0d", n_err, exp_err); else passed++;
    checks++;
    if (bytes_diff() !== 0) $display("FAIL stuff_err_bytes: got %0d bytes (first %h) required 3C only", got_q.size(), got_q.size() ? got_q[0] : 8'h00);
    else passed++;
    checks++;
    if (n_eop !== 1) $display("FAIL stuff_err_eop: got %0d required 1", n_eop); else passed++;
    checks++;
    if (n_rise !== 2) $display("FAIL stuff_err_active_rises: got %0d required 2", n_rise); else passed++;
  endtask

  task automatic test_partial_eop;
    clear_all();
    add_byte(8'hC3); add_rand_bits(3); emit(1, 1); model_packet();
    play(0); idle(20);
    checks++;
    if (bytes_diff() !== 0) $display("FAIL partial_bytes: got %0d bytes (first %h) required C3", got_q.size(), got_q.size() ? got_q[0] : 8'h00);
    else passed++;
    checks++;
    if (n_eop !== 1) $display("FAIL partial_eop: got %0d required 1", n_eop); else passed++;
    checks++;
    if (n_err !== exp_err) $display("FAIL partial_err: got %0d required %0d", n_err, exp_err); else passed++;
    checks++;
    if (n_ee !== 1) $display("FAIL partial_eop_err_same_cycle: got %0d required 1", n_ee); else passed++;
  endtask

  task automatic test_reset_mid;
    logic act_before;
    clear_all();
    add_byte(8'h5A); emit(1, 1);
    while (sym_q.size() > 16) void'(sym_q.pop_back());
    play(0);
    act_before = rx_active_o;
    #3 rst_i = 1'b0;
    #1;
    checks++;
    if (act_before !== 1'b1) $display("FAIL midreset_active_before: got %b required 1", act_before); else passed++;
    checks++;
    if ({rx_data_o, rx_valid_o, rx_active_o, rx_eop_o, rx_err_o, line_state_o} !== 14'd0)
      $display("FAIL midreset_async_clear: got %h required 0",
               {rx_data_o, rx_valid_o, rx_active_o, rx_eop_o, rx_err_o, line_state_o});
    else passed++;
    {dn_i, dp_i} = LJ;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b1;
    clear_all();
    idle(10);
    add_byte(8'h5A); emit(1, 1); model_packet();
    play(0); idle(20);
    checks++;
    if (bytes_diff() !== 0) $display("FAIL midreset_bytes: got %0d bytes (first %h) required 5A", got_q.size(), got_q.size() ? got_q[0] : 8'h00);
    else passed++;
    checks++;
    if (n_err !== 0 || n_eop !== 1) $display("FAIL midreset_flags: got err %0d eop %0d required 0 and 1", n_err, n_eop);
    else passed++;
  endtask

  task automatic test_jitter;
    clear_all();
    add_byte(8'h00); add_byte(8'h80); add_byte(8'h7E); emit(1, 1); model_packet();
    play(1); idle(20);
    checks++;
    if (bytes_diff() !== 0) $display("FAIL jitter_bytes: got %0d bytes (first %h) required 00 80 7E", got_q.size(), got_q.size() ? got_q[0] : 8'h00);
    else passed++;
    checks++;
    if (n_err !== 0) $display("FAIL jitter_err: got %0d required 0", n_err); else passed++;
    checks++;
    if (n_eop !== 1) $display("FAIL jitter_eop: got %0d required 1", n_eop); else passed++;
  endtask

  task automatic test_back_to_back;
    int nb, extra;
    clear_all();
    for (int p = 0; p < 8; p++) begin
      tx_bits.delete();
      nb = int'($urandom_range(4, 1));
      for (int i = 0; i < nb; i++) add_byte(8'($urandom));
      extra = ($urandom_range(1, 0) != 0) ? int'($urandom_range(7, 1)) : 0;
      add_rand_bits(extra);
      emit(1, 1); model_packet();
      play(1'($urandom_range(1, 0)));
    end
    idle(20);
    checks++;
    if (bytes_diff() !== 0) $display("FAIL random_bytes: got %0d bytes required %0d, %0d differ", got_q.size(), exp_q.size(), bytes_diff());
    else passed++;
    checks++;
    if (n_err !== exp_err) $display("FAIL random_err: got %0d required %0d", n_err, exp_err); else passed++;
    checks++;
    if (n_eop !== exp_eop) $display("FAIL random_eop: got %0d required %0d", n_eop, exp_eop); else passed++;
  endtask

  task automatic test_strobe_rules;
    checks++;
    if (tot_ve !== 0) $display("FAIL valid_with_err: got %0d cycles required 0", tot_ve); else passed++;
    checks++;
    if (tot_vo !== 0) $display("FAIL valid_with_eop: got %0d cycles required 0", tot_vo); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stuff_ff();
    test_stuff_error();
    test_partial_eop();
    test_reset_mid();
    test_jitter();
    test_back_to_back();
    test_strobe_rules();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
